sha3_axis_pad_tx: RTL and testbench

//  AXI-Stream message transmitter placed in front of AXI_SHA.
//  - Takes raw message words (16-bit, byte-keep) and applies SHA-3 padding (0x06 .. 0x80).
//  - Splits the stream into rate-sized blocks for the selected mode and emits it to the SHA core.
//  - TID_o marks the end of every rate block; TLAST_o marks the final word of the message.

---
 rtl/sha3_axis_pad_tx.sv | 170 +++++++++++++++++
 tb/tb_sha3_axis_pad_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sha3_axis_pad_tx.sv
// SHA-3 message padder/blocker in front of AXI_SHA: 16-bit AXI-Stream in, rate-blocked padded words out.
// Optional message byte counter on MSG_BYTES is enabled with `define PAD_TX_BYTECNT_EN.
module sha3_axis_pad_tx #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BCNT_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [WIDTH-1:0]  S_TDATA,
  input  logic [1:0]        S_TKEEP,
  input  logic [1:0]        S_TUSER,
  input  logic              S_TLAST,
  input  logic              S_TVALID,
  output logic              S_TREADY,
  output logic [WIDTH-1:0]  TDATA_o,
  output logic [1:0]        TUSER_o,
  output logic              TID_o,
  output logic              TLAST_o,
  output logic              TVALID_o,
  input  logic              TREADY,
  output logic [BCNT_W-1:0] MSG_BYTES
);

  localparam int unsigned WC_W = 7;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_FLUSH} state_t;

  state_t            state, state_n;
  logic [WC_W-1:0]   wc, wc_n, wc_adv_c, last_wc_c;
  logic [1:0]        mode, mode_n, mode_eff_c, tuser_n;
  logic              sent06, sent06_n;
  logic [WIDTH-1:0]  data_n;
  logic              tid_n, tlast_n, valid_n;
  logic              load_c, accept_c, blk_end_c;

  // Last word index of a rate block, per mode
  function automatic logic [WC_W-1:0] rate_last(input logic [1:0] m);
    case (m)
      2'd0:    rate_last = WC_W'(71);
      2'd1:    rate_last = WC_W'(67);
      2'd2:    rate_last = WC_W'(51);
      default: rate_last = WC_W'(35);
    endcase
  endfunction

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      wc       <= '0;
      mode     <= '0;
      sent06   <= 1'b0;
      TDATA_o  <= '0;
      TUSER_o  <= '0;
      TID_o    <= 1'b0;
      TLAST_o  <= 1'b0;
      TVALID_o <= 1'b0;
    end else begin
      state    <= state_n;
      wc       <= wc_n;
      mode     <= mode_n;
      sent06   <= sent06_n;
      TDATA_o  <= data_n;
      TUSER_o  <= tuser_n;
      TID_o    <= tid_n;
      TLAST_o  <= tlast_n;
      TVALID_o <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    wc_n       = wc;
    mode_n     = mode;
    sent06_n   = sent06;
    data_n     = TDATA_o;
    tuser_n    = TUSER_o;
    tid_n      = TID_o;
    tlast_n    = TLAST_o;
    valid_n    = TVALID_o && !TREADY;
    S_TREADY   = 1'b0;
    accept_c   = 1'b0;
    load_c     = !TVALID_o || TREADY;
    mode_eff_c = (state == S_IDLE) ? S_TUSER : mode;
    last_wc_c  = rate_last(mode_eff_c);
    blk_end_c  = (wc == last_wc_c);
    wc_adv_c   = blk_end_c ? '0 : wc + WC_W'(1);

    case (state)
      S_IDLE, S_DATA: begin
        S_TREADY = load_c;
        accept_c = S_TVALID && load_c;
        if (accept_c) begin
          mode_n  = mode_eff_c;
          tuser_n = mode_eff_c;
          valid_n = 1'b1;
          data_n  = S_TDATA;
          tid_n   = blk_end_c;
          tlast_n = 1'b0;
          wc_n    = wc_adv_c;
          state_n = S_DATA;
          if (S_TLAST) begin
            // keep=10 is illegal and falls into the full-word path
            case (S_TKEEP)
              2'b01:   data_n = WIDTH'({(blk_end_c ? 8'h86 : 8'h06), S_TDATA[7:0]});
              2'b00:   data_n = blk_end_c ? WIDTH'(16'h8006) : WIDTH'(16'h0006);
              default: data_n = S_TDATA;
            endcase
            if (S_TKEEP[1]) begin
              state_n  = S_PAD;
              sent06_n = 1'b0;
            end else if (blk_end_c) begin
              tlast_n  = 1'b1;
              state_n  = S_FLUSH;
            end else begin
              state_n  = S_PAD;
              sent06_n = 1'b1;
            end
          end
        end
      end
      S_PAD: begin
        if (load_c) begin
          valid_n  = 1'b1;
          tuser_n  = mode;
          data_n   = WIDTH'({(blk_end_c ? 8'h80 : 8'h00), (sent06 ? 8'h00 : 8'h06)});
          tid_n    = blk_end_c;
          tlast_n  = blk_end_c;
          sent06_n = 1'b1;
          wc_n     = wc_adv_c;
          if (blk_end_c) state_n = S_FLUSH;
        end
      end
      default: begin
        // Hold off the next message until the final word is taken
        if (TVALID_o && TREADY) state_n = S_IDLE;
      end
    endcase
  end

`ifdef PAD_TX_BYTECNT_EN
  localparam int unsigned SUM_W = BCNT_W + 1;

  logic [BCNT_W-1:0] bcnt, bbase_c;
  logic [1:0]        badd_c;
  logic [SUM_W-1:0]  bsum_c;

  always_comb begin
    badd_c = 2'd0;
    if (accept_c) begin
      if (!S_TLAST || S_TKEEP[1]) badd_c = 2'd2;
      else if (S_TKEEP[0])        badd_c = 2'd1;
    end
    bbase_c = (state == S_IDLE) ? '0 : bcnt;
    bsum_c  = SUM_W'(bbase_c) + SUM_W'(badd_c);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bcnt      <= '0;
      MSG_BYTES <= '0;
    end else begin
      if (accept_c) bcnt <= bsum_c[BCNT_W] ? '1 : bsum_c[BCNT_W-1:0];
      if (state == S_FLUSH && TVALID_o && TREADY) MSG_BYTES <= bcnt;
    end
  end
`else
  assign MSG_BYTES = '0;
`endif

endmodule

// File: tb/tb_sha3_axis_pad_tx.sv
// Randomized bench for sha3_axis_pad_tx against a byte-level SHA-3 padding model.
module tb_sha3_axis_pad_tx;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [15:0] S_TDATA = '0;
  logic [1:0]  S_TKEEP = '0;
  logic [1:0]  S_TUSER = '0;
  logic        S_TLAST = 1'b0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic [15:0] TDATA_o;
  logic [1:0]  TUSER_o;
  logic        TID_o;
  logic        TLAST_o;
  logic        TVALID_o;
  logic        TREADY = 1'b1;
  logic [31:0] MSG_BYTES;

  sha3_axis_pad_tx #(.WIDTH(16), .BCNT_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TUSER(S_TUSER), .S_TLAST(S_TLAST),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .TDATA_o(TDATA_o), .TUSER_o(TUSER_o), .TID_o(TID_o), .TLAST_o(TLAST_o),
    .TVALID_o(TVALID_o), .TREADY(TREADY), .MSG_BYTES(MSG_BYTES)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output word record: {tuser, tid, tlast, data}
  wire [19:0]  cur = {TUSER_o, TID_o, TLAST_o, TDATA_o};
  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];
  logic [7:0]  msg[$];
  int          ready_mode = 0;
  bit          in_pad = 0;
  bit          prev_stall = 0;
  logic [19:0] prev = '0;

  always @(posedge ACLK) begin
    #1;
    case (ready_mode)
      0:       TREADY = 1'b1;
      1:       TREADY = ~TREADY;
      default: TREADY = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: collect handshaked words, check stall stability and no input acceptance during padding
  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) check_eq("stall_hold", {11'd0, TVALID_o, cur}, {11'd0, 1'b1, prev});
      if (in_pad) check_eq("pad_sready", {31'd0, S_TREADY}, 32'd0);
      if (TVALID_o && TREADY) begin
        got_q.push_back(cur);
        if (TLAST_o) in_pad = 0;
      end
      prev_stall = TVALID_o && !TREADY;
      prev = cur;
    end
  end

  // Reference: message bytes + 0x06, zero-fill to the SHA-3 rate, 0x80 into the final byte
  task automatic build_exp(input logic [1:0] mode);
    int dbits;
    int rate_b;
    int nw;
    logic [7:0] p[$];
    case (mode)
      2'd0:    dbits = 224;
      2'd1:    dbits = 256;
      2'd2:    dbits = 384;
      default: dbits = 512;
    endcase
    rate_b = 200 - 2 * (dbits / 8);
    p = msg;
    p.push_back(8'h06);
    while ((p.size() % rate_b) != 0) p.push_back(8'h00);
    p[p.size() - 1] = p[p.size() - 1] | 8'h80;
    nw = p.size() / 2;
    exp_q.delete();
    for (int i = 0; i < nw; i++)
      exp_q.push_back({mode, 1'(((i + 1) % (rate_b / 2)) == 0), 1'(i == nw - 1), p[2*i+1], p[2*i]});
  endtask

  task automatic beat(input logic [15:0] d, input logic [1:0] k, input logic [1:0] u, input logic l);
    @(negedge ACLK);
    S_TDATA = d; S_TKEEP = k; S_TUSER = u; S_TLAST = l; S_TVALID = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      #1;
      if (S_TREADY) begin
        @(posedge ACLK);
        return;
      end
      @(negedge ACLK);
    end
    check_eq("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_msg(input string tag, input logic [1:0] mode, input int nfull,
                         input logic [1:0] keep, input logic [7:0] b0, input bit lat_chk);
    logic [15:0] d;
    int t;
    msg.delete();
    got_q.delete();
    for (int i = 0; i < nfull; i++) begin
      d = 16'($urandom);
      msg.push_back(d[7:0]);
      msg.push_back(d[15:8]);
      beat(d, 2'b11, (i == 0) ? mode : 2'($urandom), 1'b0);
    end
    d = 16'($urandom);
    if (keep == 2'b01) d[7:0] = b0;
    if (keep[1]) begin
      msg.push_back(d[7:0]);
      msg.push_back(d[15:8]);
    end else if (keep[0]) begin
      msg.push_back(d[7:0]);
    end
    build_exp(mode);
    beat(d, keep, (nfull == 0) ? mode : 2'($urandom), 1'b1);
    in_pad = !(exp_q.size() == msg.size() / 2 + 1 && nfull == 0 && exp_q.size() == 1);
    @(negedge ACLK);
    S_TVALID = 1'b0;
    if (lat_chk) begin
      check_eq({tag, "_lat_valid"}, {31'd0, TVALID_o}, 32'd1);
      check_eq({tag, "_lat_w0"}, {12'd0, cur}, {12'd0, exp_q[0]});
    end
    t = 0;
    while (got_q.size() < exp_q.size() && t < 5000) begin
      @(negedge ACLK);
      t++;
    end
    @(negedge ACLK);
    @(negedge ACLK);
    check_eq({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), {12'd0, got_q[i]}, {12'd0, exp_q[i]});
`ifdef PAD_TX_BYTECNT_EN
    check_eq({tag, "_msg_bytes"}, MSG_BYTES, msg.size());
`else
    check_eq({tag, "_msg_bytes"}, MSG_BYTES, 32'd0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_eq("rst_tvalid", {31'd0, TVALID_o}, 32'd0);
    check_eq("rst_word", {12'd0, cur}, 32'd0);
    check_eq("rst_msg_bytes", MSG_BYTES, 32'd0);
    ARESET = 1'b0;

    run_msg("empty_m1", 2'd1, 0, 2'b00, 8'h00, 1'b1);
    run_msg("byte_m3", 2'd3, 0, 2'b01, 8'hAB, 1'b1);
    run_msg("full36_m3", 2'd3, 35, 2'b11, 8'h00, 1'b0);
    run_msg("w71_m0", 2'd0, 71, 2'b01, 8'h5A, 1'b0);
    run_msg("keep10_m2", 2'd2, 5, 2'b10, 8'h00, 1'b0);

    ready_mode = 1;
    run_msg("byte_m3_alt", 2'd3, 0, 2'b01, 8'hAB, 1'b0);

    // Reset during padding, then the same message must come out intact
    ready_mode = 0;
    beat(16'h00AB, 2'b01, 2'd3, 1'b1);
    @(negedge ACLK);
    S_TVALID = 1'b0;
    repeat (4) @(negedge ACLK);
    in_pad = 0;
    ARESET = 1'b1;
    @(negedge ACLK);
    check_eq("rst_mid_tvalid", {31'd0, TVALID_o}, 32'd0);
    check_eq("rst_mid_word", {12'd0, cur}, 32'd0);
    ARESET = 1'b0;
    run_msg("after_rst", 2'd3, 0, 2'b01, 8'hAB, 1'b1);

    ready_mode = 2;
    for (int n = 0; n < 14; n++)
      run_msg($sformatf("rnd%0d", n), 2'($urandom), $urandom_range(0, 150), 2'($urandom), 8'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
